// File: rtl/if_id_stage.sv
// IF/ID pipeline register: pairs each instruction-SRAM read with its PC and
// holds the returned instruction across stalls, with fetch/stall counters.
module if_id_stage #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall,
   input  logic              flush,
   input  logic [PC_W-1:0]   if_pc,
   input  logic              if_ce,
   input  logic [INST_W-1:0] inst_sram_rdata,
   output logic              id_valid,
   output logic [PC_W-1:0]   id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic [CNT_W-1:0]  perf_fetch_cnt,
   output logic [CNT_W-1:0]  perf_stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LIVE  = 2'd1,
      HELD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_next;
   logic [PC_W-1:0]   req_pc;
   logic              req_v;
   logic [INST_W-1:0] hold_inst;
   logic [CNT_W-1:0]  fetch_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   // LIVE moves to HELD on the first stall edge, while SRAM data is still good
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = EMPTY;
      end else if (!stall) begin
         state_next = if_ce ? LIVE : EMPTY;
      end else if (state == LIVE) begin
         state_next = HELD;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_pc <= '0;
         req_v  <= 1'b0;
      end else if (flush) begin
         req_v  <= 1'b0;
      end else if (!stall) begin
         req_pc <= if_pc;
         req_v  <= if_ce;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_inst <= '0;
      end else if (!flush && stall && (state == LIVE)) begin
         hold_inst <= inst_sram_rdata;
      end
   end

   // Counters wrap naturally; a flush edge counts as neither fetch nor stall
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else if (req_v && !flush) begin
         if (stall) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end else begin
            fetch_cnt <= fetch_cnt + CNT_ONE;
         end
      end
   end

   always_comb begin
      id_inst = '0;
      unique case (state)
         LIVE:    id_inst = inst_sram_rdata;
         HELD:    id_inst = hold_inst;
         default: id_inst = '0;
      endcase
   end

   assign id_valid       = req_v;
   assign id_pc          = req_pc;
   assign perf_fetch_cnt = fetch_cnt;
   assign perf_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random traffic
// compared against a bundle-level reference model (4-bit counters to hit wrap).
module tb_if_id_stage;

   logic        clk;
   logic        resetn;
   logic        stall;
   logic        flush;
   logic [31:0] if_pc;
   logic        if_ce;
   logic [31:0] inst_sram_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [3:0]  perf_fetch_cnt;
   logic [3:0]  perf_stall_cnt;

   int checks = 0;
   int fails  = 0;

   // Reference model: the bundle ID should see, plus expected counters
   logic        mv;
   logic [31:0] mpc;
   logic [31:0] minst;
   logic [3:0]  mfetch;
   logic [3:0]  mstall;
   logic        prev_launch;
   logic [31:0] prev_pc;
   logic [31:0] garbage;

   if_id_stage #(.PC_W(32), .INST_W(32), .CNT_W(4)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .stall           (stall),
      .flush           (flush),
      .if_pc           (if_pc),
      .if_ce           (if_ce),
      .inst_sram_rdata (inst_sram_rdata),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_stall_cnt  (perf_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_fn(input logic [31:0] pc);
      case (pc)
         32'hBFC0_0000: return 32'h3C08_BFC0;
         32'h0000_0104: return 32'h2402_0001;
         default:       return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      endcase
   endfunction

   function automatic logic [31:0] exp_inst();
      return mv ? minst : 32'h0;
   endfunction

   task automatic model_reset();
      mv = 1'b0; mpc = '0; minst = '0; mfetch = '0; mstall = '0;
      prev_launch = 1'b0; prev_pc = '0;
   endtask

   // SRAM answers only the cycle after a non-stalled launch; otherwise junk
   task automatic apply_stimulus(input logic ce, input logic [31:0] pc,
                                 input logic st, input logic fl);
      if_ce = ce; if_pc = pc; stall = st; flush = fl;
      inst_sram_rdata = prev_launch ? mem_fn(prev_pc) : garbage;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (flush) begin
         mv = 1'b0;
      end else if (!stall) begin
         if (mv) mfetch = mfetch + 4'd1;
         mv = if_ce; mpc = if_pc; minst = mem_fn(if_pc);
      end else if (mv) begin
         mstall = mstall + 4'd1;
      end
      prev_launch = if_ce && !stall;
      prev_pc = if_pc;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      model_reset();
      @(posedge clk); #1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", id_valid); end
      checks++; if (id_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc: got %h want 0", id_pc); end
      checks++; if (id_inst !== 32'h0) begin fails++; $display("[TB] FAIL reset_inst: got %h want 0", id_inst); end
      checks++; if (perf_fetch_cnt !== 4'd0 || perf_stall_cnt !== 4'd0) begin
         fails++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_first_fetch();
      apply_stimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b1) begin fails++; $display("[TB] FAIL first_valid: got %b want 1", id_valid); end
      checks++; if (id_pc !== 32'hBFC0_0000) begin fails++; $display("[TB] FAIL first_pc: got %h want bfc00000", id_pc); end
      checks++; if (id_inst !== 32'h3C08_BFC0) begin fails++; $display("[TB] FAIL first_inst: got %h want 3c08bfc0", id_inst); end
      tick();
      checks++; if (perf_fetch_cnt !== 4'd1) begin fails++; $display("[TB] FAIL first_cnt: got %0d want 1", perf_fetch_cnt); end
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
         fails++; $display("[TB] FAIL bubble: got %b/%h want 0/0", id_valid, id_inst);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] f0;
      logic [31:0] pcs [3];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
      f0 = perf_fetch_cnt;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i < 3, (i < 3) ? pcs[i] : 32'h0, 1'b0, 1'b0);
         if (i > 0) begin
            checks++; if (id_valid !== 1'b1 || id_pc !== pcs[i-1] || id_inst !== mem_fn(pcs[i-1])) begin
               fails++; $display("[TB] FAIL b2b_%0d: got %b/%h/%h want 1/%h/%h", i, id_valid, id_pc, id_inst, pcs[i-1], mem_fn(pcs[i-1]));
            end
         end
         tick();
      end
      checks++; if (perf_fetch_cnt !== f0 + 4'd3) begin fails++; $display("[TB] FAIL b2b_cnt: got %0d want %0d", perf_fetch_cnt, f0 + 4'd3); end
   endtask

   task automatic test_stall_hold();
      logic [3:0] s0;
      garbage = 32'hDEAD_BEEF;
      apply_stimulus(1'b1, 32'h104, 1'b0, 1'b0);
      tick();
      s0 = perf_stall_cnt;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 32'h108, i < 3, 1'b0);
         checks++; if (id_valid !== 1'b1 || id_pc !== 32'h104 || id_inst !== 32'h2402_0001) begin
            fails++; $display("[TB] FAIL stall_hold_%0d: got %b/%h/%h want 1/00000104/24020001", i, id_valid, id_pc, id_inst);
         end
         tick();
      end
      checks++; if (perf_stall_cnt !== s0 + 4'd3) begin fails++; $display("[TB] FAIL stall_cnt: got %0d want %0d", perf_stall_cnt, s0 + 4'd3); end
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h108 || id_inst !== mem_fn(32'h108)) begin
         fails++; $display("[TB] FAIL stall_release: got %b/%h/%h want 1/00000108/%h", id_valid, id_pc, id_inst, mem_fn(32'h108));
      end
      tick();
   endtask

   task automatic test_flush();
      logic [3:0] f0;
      logic [3:0] s0;
      apply_stimulus(1'b1, 32'h200, 1'b0, 1'b0);
      tick();
      f0 = perf_fetch_cnt; s0 = perf_stall_cnt;
      apply_stimulus(1'b1, 32'h204, 1'b1, 1'b1);
      tick();
      apply_stimulus(1'b1, 32'h208, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
         fails++; $display("[TB] FAIL flush_out: got %b/%h want 0/0", id_valid, id_inst);
      end
      checks++; if (perf_fetch_cnt !== f0 || perf_stall_cnt !== s0) begin
         fails++; $display("[TB] FAIL flush_cnt: got %0d/%0d want %0d/%0d", perf_fetch_cnt, perf_stall_cnt, f0, s0);
      end
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h208) begin
         fails++; $display("[TB] FAIL flush_next: got %b/%h want 1/00000208", id_valid, id_pc);
      end
      tick();
   endtask

   task automatic test_async_reset();
      garbage = 32'hCAFE_F00D;
      apply_stimulus(1'b1, 32'h300, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h304, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h304, 1'b1, 1'b0);
      #2 resetn = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
         fails++; $display("[TB] FAIL async_out: got %b/%h/%h want 0/0/0", id_valid, id_pc, id_inst);
      end
      checks++; if (perf_fetch_cnt !== 4'd0 || perf_stall_cnt !== 4'd0) begin
         fails++; $display("[TB] FAIL async_cnt: got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
         fails++; $display("[TB] FAIL async_stale: got %b/%h want 0/0", id_valid, id_inst);
      end
      tick();
   endtask

   task automatic test_counter_wrap();
      int n = 0;
      while (mfetch != 4'hF && n < 40) begin
         apply_stimulus(1'b1, 32'h400 + 32'(n * 4), 1'b0, 1'b0);
         tick();
         n++;
      end
      apply_stimulus(1'b1, 32'h500, 1'b0, 1'b0);
      checks++; if (perf_fetch_cnt !== 4'hF) begin fails++; $display("[TB] FAIL wrap_pre: got %0d want 15", perf_fetch_cnt); end
      tick();
      checks++; if (perf_fetch_cnt !== 4'h0) begin fails++; $display("[TB] FAIL wrap: got %0d want 0", perf_fetch_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         garbage = $urandom;
         apply_stimulus(($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                        ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
         checks++; if (id_valid !== mv) begin fails++; $display("[TB] FAIL rand_valid %0d: got %b want %b", i, id_valid, mv); end
         checks++; if (id_pc !== mpc) begin fails++; $display("[TB] FAIL rand_pc %0d: got %h want %h", i, id_pc, mpc); end
         checks++; if (id_inst !== exp_inst()) begin fails++; $display("[TB] FAIL rand_inst %0d: got %h want %h", i, id_inst, exp_inst()); end
         checks++; if (perf_fetch_cnt !== mfetch) begin fails++; $display("[TB] FAIL rand_fetch %0d: got %0d want %0d", i, perf_fetch_cnt, mfetch); end
         checks++; if (perf_stall_cnt !== mstall) begin fails++; $display("[TB] FAIL rand_stall %0d: got %0d want %0d", i, perf_stall_cnt, mstall); end
         tick();
      end
   endtask

   initial begin
      resetn = 1'b0; stall = 1'b0; flush = 1'b0; if_pc = '0; if_ce = 1'b0;
      inst_sram_rdata = '0; garbage = 32'hDEAD_BEEF;
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_stall_hold();
      test_flush();
      test_async_reset();
      test_counter_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
